dataflow_fifo: RTL
==================

# dataflow_fifo

Elastic valid/ready FIFO placed directly downstream of the combinational `arith_*` operator units. It captures each `result_valid`/`result_data` token and re-presents it to the next consumer. Its purpose is to break the combinational ready/valid chain between chained operators and to absorb short consumer stalls. Tokens leave in arrival order; none is dropped or duplicated.

## Interface
Parameters:
- `WIDTH`, 32: token width in bits; any value ≥ 1.
- `DEPTH`, 4: number of storage entries; any value ≥ 2. Need not be a power of two.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  producer has a token (driven from an operator's `result_valid`).
- `in_ready`  out  1  FIFO accepts a token this cycle (drives the operator's `result_ready`).
- `in_data`  in  WIDTH  token payload.
- `out_valid`  out  1  head token is available.
- `out_ready`  in  1  consumer takes the head token this cycle.
- `out_data`  out  WIDTH  head token payload.
- `count`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

## Operation
- Storage is a circular buffer `mem[DEPTH]` with read pointer `rd_ptr`, write pointer `wr_ptr` and occupancy counter `cnt`.
- Push occurs when `in_valid & in_ready`:
  - `mem[wr_ptr] <= in_data`.
  - `wr_ptr` advances, wrapping from DEPTH-1 to 0.
- Pop occurs when `out_valid & out_ready`:
  - `rd_ptr` advances, wrapping from DEPTH-1 to 0.
- Occupancy update:
  - push only: `cnt+1`.
  - pop only: `cnt-1`.
  - push and pop together: unchanged.
  - neither: unchanged.
- Output derivation:
  - `in_ready = rst_n & (cnt != DEPTH)`. It does not depend on `out_ready`, so a full FIFO does not accept a token in the same cycle as a pop.
  - `out_valid = (cnt != 0)`.
  - `out_data = mem[rd_ptr]` when `cnt != 0`, otherwise `'0`.
  - `count = cnt`.
- Full plus push attempt (`cnt == DEPTH`, `in_valid=1`): no write, and the producer holds its token.
- Empty plus pop attempt (`cnt == 0`, `out_ready=1`): no state change.
- The counter never exceeds DEPTH and never underflows. Exceeding DEPTH is an assertion failure in simulation.
- `mem` has no reset. Its contents are unobservable because of the `out_data` masking above.

## Timing
- Reset values (asynchronous, while `rst_n=0`):
  - `rd_ptr = wr_ptr = cnt = 0`.
  - `out_valid=0`, `out_data=0`, `count=0`, `in_ready=0`.
  - `in_ready` rises combinationally when `rst_n` deasserts.
- Reset asserted mid-operation: all stored tokens are discarded immediately. After release the FIFO is empty.
- Latency without bypass: a token pushed at edge N is visible on `out_data` and `out_valid` after edge N, i.e. 1 cycle.
- Throughput: 1 token per cycle sustained when `0 < cnt < DEPTH` and both sides are active.
- Handshake rules:
  - Producer: `in_data` is stable while `in_valid=1` and `in_ready=0`, and `in_valid` is not withdrawn in that state.
  - FIFO: keeps `out_valid` and `out_data` stable until popped.

## Configuration
- Macro: `LOOM_FIFO_BYPASS_EN`.
- Defined: zero-latency bypass when empty.
  - When `cnt == 0`: `out_valid = in_valid` and `out_data = in_data`.
  - If `out_ready=1` in that cycle, the token passes straight through. No write happens and the pointers are unchanged.
  - If `out_ready=0`, the token is pushed normally.
  - This creates a combinational path from `in_*` to `out_*`, but never from `out_ready` to `in_ready`.
- Undefined: no bypass path. Minimum latency is 1 cycle, and `out_*` depends only on registered state.

## Test plan
- Fill/drain, DEPTH=4: push 0x11, 0x22, 0x33, 0x44 with `out_ready=0`.
  - `count=4` and `in_ready=0`.
  - A 5th push of 0x55 is held.
  - Then `out_ready=1` pops 0x11, 0x22, 0x33, 0x44 in order, after which 0x55 is accepted.
- Simultaneous push and pop at `cnt=2`: `count` stays 2 and the head advances. At `cnt=4` with `out_ready=1`, `in_ready` stays 0 that cycle.
- Wrap-around, DEPTH=3: stream 10 tokens 0..9 with an alternating `out_ready` pattern. Output is exactly 0..9, and the pointers wrap at 2→0 without loss.
- Reset mid-operation: load 3 tokens, pulse `rst_n` low between edges.
  - Immediately `out_valid=0`, `count=0`, `out_data=0`, `in_ready=0`.
  - After release, the first push of 0xAA is the first token popped.
- Empty pop: with `cnt=0` and `out_ready=1` for 5 cycles, `count` stays 0 and the pointers are unchanged.
- Bypass (`LOOM_FIFO_BYPASS_EN`):
  - Empty FIFO, `in_valid=1`, `in_data=0xBEEF`, `out_ready=1`: `out_valid=1` and `out_data=0xBEEF` in the same cycle, and `count` stays 0.
  - Without the macro: `out_valid` rises 1 cycle later.

Source files
------------

// File: rtl/dataflow_fifo.sv
// Elastic valid/ready FIFO that decouples chained arith_* operators and absorbs consumer stalls.
// Optional zero-latency empty bypass is enabled by defining LOOM_FIFO_BYPASS_EN.
`timescale 1ns/1ps
module dataflow_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             empty;
  logic             full;
  logic             bypass;
  logic             do_push;
  logic             do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL);
  // Ready never looks at out_ready, so no combinational path runs back upstream.
  assign in_ready = rst_n & ~full;

`ifdef LOOM_FIFO_BYPASS_EN
  logic byp_valid;
  assign byp_valid = in_valid & rst_n;
  assign bypass    = empty & byp_valid & out_ready;
  assign out_valid = empty ? byp_valid : 1'b1;
  assign out_data  = empty ? (byp_valid ? in_data : '0) : mem[rd_ptr];
`else
  assign bypass    = 1'b0;
  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr];
`endif

  // A bypassed token is consumed directly, so it is neither written nor popped.
  assign do_push = in_valid & in_ready & ~bypass;
  assign do_pop  = ~empty & out_ready;
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt <= FULL);

endmodule
